// File: rtl/floo_vc_out_alloc.sv
// Output-port VC allocator: per-VC credits, wormhole VC ownership,
// and a registered VC assignment toward the output pipeline stage.
module floo_vc_out_alloc #(
  parameter int unsigned NumVC       = 4,
  parameter int unsigned NumVCWidth  = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned NumInputs   = 5,
  parameter int unsigned VCDepth     = 3,
  parameter int unsigned CreditWidth = $clog2(VCDepth + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  sa_global_v_i,
  input  logic [NumInputs-1:0]                  sa_global_input_dir_oh_i,
  input  logic [NumInputs-1:0][NumVCWidth-1:0]  preferred_vc_i,
  input  logic [NumInputs-1:0]                  head_i,
  input  logic [NumInputs-1:0]                  tail_i,
  input  logic                                  require_correct_vc_i,
  input  logic                                  credit_v_i,
  input  logic [NumVCWidth-1:0]                 credit_id_i,
  output logic                                  vc_assignment_v_o,
  output logic [NumVCWidth-1:0]                 vc_assignment_id_o,
  output logic [NumInputs-1:0]                  vc_assignment_input_oh_o,
  output logic [NumVC-1:0]                      vc_avail_o,
  output logic                                  err_o
);

  localparam int unsigned SelW = NumInputs > 1 ? $clog2(NumInputs) : 1;
  localparam logic [CreditWidth-1:0] Full = CreditWidth'(VCDepth);

  logic [CreditWidth-1:0] credit_q [NumVC];
  logic [CreditWidth-1:0] credit_d [NumVC];
  logic [NumVC-1:0]       owned_q;
  logic [NumInputs-1:0]   open_q;
  logic [NumVCWidth-1:0]  vc_q [NumInputs];
  logic                   err_q;

  logic [NumVC-1:0]       avail;
  logic [SelW-1:0]        sel;
  logic                   sel_head;
  logic                   sel_tail;
  logic                   sel_open;
  logic [NumVCWidth-1:0]  pref;
  logic                   grant;
  logic [NumVCWidth-1:0]  cand_id;
  logic                   proto_err;
  logic                   ovf;

  // A VC is free for a new packet when nobody owns it and it has credit.
  always_comb begin
    for (int v = 0; v < NumVC; v++) begin
      avail[v] = !owned_q[v] && (credit_q[v] != '0);
    end
  end

  assign vc_avail_o = avail;
  assign err_o      = err_q;

  // Decode the winning input index from the one-hot grant.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (sa_global_input_dir_oh_i[i]) sel = i[SelW-1:0];
    end
  end

  assign sel_head = head_i[sel];
  assign sel_tail = tail_i[sel];
  assign sel_open = open_q[sel];
  assign pref     = preferred_vc_i[sel];

  // Pick a downstream VC for the winning flit, or flag a protocol error.
  always_comb begin
    grant     = 1'b0;
    cand_id   = '0;
    proto_err = 1'b0;
    if (sa_global_v_i) begin
      if (!$onehot(sa_global_input_dir_oh_i)) begin
        proto_err = 1'b1;
      end else if (sel_head == sel_open) begin
        proto_err = 1'b1;
      end else if (sel_open) begin
        if (credit_q[vc_q[sel]] != '0) begin
          grant   = 1'b1;
          cand_id = vc_q[sel];
        end
      end else if (avail[pref]) begin
        grant   = 1'b1;
        cand_id = pref;
      end else if (!require_correct_vc_i) begin
        for (int v = NumVC - 1; v >= 0; v--) begin
          if (avail[v]) begin
            grant   = 1'b1;
            cand_id = v[NumVCWidth-1:0];
          end
        end
      end
    end
  end

  // Next credit counts; a return and a consume on one VC cancel out.
  always_comb begin
    ovf = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      logic inc;
      logic dec;
      inc = credit_v_i && (credit_id_i == v[NumVCWidth-1:0]);
      dec = grant && (cand_id == v[NumVCWidth-1:0]);
      credit_d[v] = credit_q[v];
      if (inc && !dec) begin
        if (credit_q[v] == Full) ovf = 1'b1;
        else credit_d[v] = credit_q[v] + CreditWidth'(1);
      end else if (dec && !inc) begin
        credit_d[v] = credit_q[v] - CreditWidth'(1);
      end
    end
  end

  // Commit credits, ownership, packet state and the registered result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NumVC; v++) credit_q[v] <= Full;
      for (int i = 0; i < NumInputs; i++) vc_q[i] <= '0;
      owned_q                  <= '0;
      open_q                   <= '0;
      err_q                    <= 1'b0;
      vc_assignment_v_o        <= 1'b0;
      vc_assignment_id_o       <= '0;
      vc_assignment_input_oh_o <= '0;
    end else begin
      for (int v = 0; v < NumVC; v++) credit_q[v] <= credit_d[v];
      if (grant) begin
        if (sel_head && !sel_tail) begin
          owned_q[cand_id] <= 1'b1;
          open_q[sel]      <= 1'b1;
          vc_q[sel]        <= cand_id;
        end else if (sel_tail) begin
          owned_q[cand_id] <= 1'b0;
          open_q[sel]      <= 1'b0;
        end
      end
      err_q                    <= err_q | proto_err | ovf;
      vc_assignment_v_o        <= grant;
      vc_assignment_id_o       <= grant ? cand_id : '0;
      vc_assignment_input_oh_o <= grant ? sa_global_input_dir_oh_i : '0;
    end
  end

endmodule

// File: tb/tb_floo_vc_out_alloc.sv
// Directed scoreboard bench for floo_vc_out_alloc
// (4 VCs, 5 inputs, depth 3).
module tb_floo_vc_out_alloc;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sa_v = 1'b0;
  logic [4:0]      sa_oh = '0;
  logic [4:0][1:0] pref = '0;
  logic [4:0]      head = '0;
  logic [4:0]      tail = '0;
  logic            rc = 1'b0;
  logic            cv = 1'b0;
  logic [1:0]      cid = '0;
  logic            av;
  logic [1:0]      aid;
  logic [4:0]      aoh;
  logic [3:0]      avail;
  logic            err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] id;
    logic [4:0] oh;
  } exp_t;

  exp_t sb[$];

  floo_vc_out_alloc dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .sa_global_v_i            (sa_v),
    .sa_global_input_dir_oh_i (sa_oh),
    .preferred_vc_i           (pref),
    .head_i                   (head),
    .tail_i                   (tail),
    .require_correct_vc_i     (rc),
    .credit_v_i               (cv),
    .credit_id_i              (cid),
    .vc_assignment_v_o        (av),
    .vc_assignment_id_o       (aid),
    .vc_assignment_input_oh_o (aoh),
    .vc_avail_o               (avail),
    .err_o                    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] oh,
                      input logic sv, input logic h, input logic t,
                      input logic [1:0] pv, input logic r,
                      input logic c, input logic [1:0] ci,
                      input logic ev, input logic [1:0] eid);
    exp_t e;
    @(negedge clk);
    sa_v  = sv;
    sa_oh = oh;
    head  = h ? 5'h1f : 5'h00;
    tail  = t ? 5'h1f : 5'h00;
    pref  = {5{pv}};
    rc    = r;
    cv    = c;
    cid   = ci;
    sb.push_back('{ev, eid, ev ? oh : 5'h00});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".v"}, 32'(av), 32'(e.v));
    if (e.v) begin
      chk({tag, ".id"}, 32'(aid), 32'(e.id));
      chk({tag, ".oh"}, 32'(aoh), 32'(e.oh));
    end
  endtask

  task automatic idle(input string tag, input logic c,
                      input logic [1:0] ci);
    step(tag, 5'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, c, ci, 1'b0, 2'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst  = 1'b1;
    sa_v = 1'b0;
    cv   = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".rst_v"}, 32'(av), 32'd0);
    chk({tag, ".rst_avail"}, 32'(avail), 32'hf);
    chk({tag, ".rst_err"}, 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, ".post_v"}, 32'(av), 32'd0);
  endtask

  initial begin
    do_reset("reset0");

    step("single", 5'b00100, 1, 1, 1, 2'd1, 0, 0, 2'd0, 1, 2'd1);
    chk("single.avail", 32'(avail), 32'hf);

    step("wh_head", 5'b00001, 1, 1, 0, 2'd3, 0, 0, 2'd0, 1, 2'd3);
    chk("wh_head.avail", 32'(avail), 32'h7);
    step("wh_block", 5'b00010, 1, 1, 0, 2'd3, 1, 1, 2'd3, 0, 2'd0);
    step("wh_body1", 5'b00001, 1, 0, 0, 2'd0, 1, 0, 2'd0, 1, 2'd3);
    step("wh_body2", 5'b00001, 1, 0, 0, 2'd1, 0, 0, 2'd0, 1, 2'd3);
    step("wh_tail", 5'b00001, 1, 0, 1, 2'd2, 1, 0, 2'd0, 1, 2'd3);
    chk("wh_tail.avail", 32'(avail), 32'h7);

    step("fb_own", 5'b01000, 1, 1, 0, 2'd2, 0, 0, 2'd0, 1, 2'd2);
    chk("fb_own.avail", 32'(avail), 32'h3);
    step("fb_low", 5'b10000, 1, 1, 1, 2'd2, 0, 0, 2'd0, 1, 2'd0);
    step("fb_strict", 5'b10000, 1, 1, 1, 2'd2, 1, 0, 2'd0, 0, 2'd0);
    step("fb_tail", 5'b01000, 1, 0, 1, 2'd0, 0, 0, 2'd0, 1, 2'd2);
    chk("fb_tail.avail", 32'(avail), 32'h7);

    idle("ex_ret", 1, 2'd0);
    for (int k = 0; k < 3; k++)
      step("ex_g", 5'b00100, 1, 1, 1, 2'd0, 1, 0, 2'd0, 1, 2'd0);
    chk("ex.avail", 32'(avail), 32'h6);
    step("ex_same", 5'b00100, 1, 1, 1, 2'd0, 1, 1, 2'd0, 0, 2'd0);
    step("ex_next", 5'b00100, 1, 1, 1, 2'd0, 1, 0, 2'd0, 1, 2'd0);

    step("sim", 5'b00100, 1, 1, 1, 2'd1, 1, 1, 2'd1, 1, 2'd1);
    step("sim_g1", 5'b00100, 1, 1, 1, 2'd1, 1, 0, 2'd0, 1, 2'd1);
    step("sim_g2", 5'b00100, 1, 1, 1, 2'd1, 1, 0, 2'd0, 1, 2'd1);
    step("sim_g3", 5'b00100, 1, 1, 1, 2'd1, 1, 0, 2'd0, 0, 2'd0);

    for (int k = 0; k < 3; k++) idle("ov_ret", 1, 2'd1);
    chk("ov.err_before", 32'(err), 32'd0);
    idle("ov_over", 1, 2'd1);
    chk("ov.err_set", 32'(err), 32'd1);
    idle("ov_idle", 0, 2'd0);
    chk("ov.err_sticky", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++)
      step("ov_g", 5'b00100, 1, 1, 1, 2'd1, 1, 0, 2'd0, 1, 2'd1);
    step("ov_g4", 5'b00100, 1, 1, 1, 2'd1, 1, 0, 2'd0, 0, 2'd0);

    do_reset("reset1");
    step("er_body", 5'b00010, 1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0);
    chk("er_body.err", 32'(err), 32'd1);
    step("er_open", 5'b00001, 1, 1, 0, 2'd2, 1, 0, 2'd0, 1, 2'd2);
    chk("er_open.avail", 32'(avail), 32'hb);

    do_reset("reset2");
    step("rr_head", 5'b00001, 1, 1, 0, 2'd2, 1, 0, 2'd0, 1, 2'd2);
    chk("rr_head.err", 32'(err), 32'd0);
    step("rr_dup", 5'b00001, 1, 1, 0, 2'd1, 0, 0, 2'd0, 0, 2'd0);
    chk("rr_dup.err", 32'(err), 32'd1);

    do_reset("reset3");
    step("oh_bad", 5'b00011, 1, 1, 1, 2'd0, 0, 0, 2'd0, 0, 2'd0);
    chk("oh_bad.err", 32'(err), 32'd1);
    chk("oh_bad.avail", 32'(avail), 32'hf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
